// File: rtl/fpnew_issue_arbiter.sv
// fpnew_issue_arbiter: round-robin sharing of one FPNew instance among NUM_REQ requesters,
// with tag-based result steering, an in-flight limit, flush and malformed-tag recovery.
module fpnew_issue_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int PAYLOAD_W    = 210,
    parameter  int FLEN         = 64,
    parameter  int MAX_INFLIGHT = 8,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_data_i,
    output logic                              fpu_valid_o,
    input  logic                              fpu_ready_i,
    output logic [PAYLOAD_W-1:0]              fpu_data_o,
    output logic [ID_W-1:0]                   fpu_tag_o,
    output logic                              fpu_flush_o,
    input  logic                              fpu_rvalid_i,
    output logic                              fpu_rready_o,
    input  logic [ID_W-1:0]                   fpu_rtag_i,
    input  logic [FLEN-1:0]                   fpu_result_i,
    input  logic [4:0]                        fpu_status_i,
    output logic [NUM_REQ-1:0]                rsp_valid_o,
    input  logic [NUM_REQ-1:0]                rsp_ready_i,
    output logic [FLEN-1:0]                   rsp_result_o,
    output logic [4:0]                        rsp_status_o,
    input  logic                              flush_i,
    output logic [7:0]                        inflight_o,
    output logic                              busy_o,
    output logic                              tag_err_o
);
    localparam int TAGS = 2**ID_W;

    logic [ID_W-1:0]    rr_ptr, lock_idx, rr_g, grant;
    logic               lock, issue_ok, issue_hs, rsp_hs, tag_ok, found;
    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;
    logic [TAGS-1:0]    rdy_pad;
    logic [7:0]         inflight;

    // Rotate valids so bit 0 is rr_ptr, take the first set bit, map back to an index.
    always_comb begin
        rot   = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr);
        rr_g  = rr_ptr;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                sum   = {1'b0, rr_ptr} + (ID_W+1)'(i);
                rr_g  = sum >= (ID_W+1)'(NUM_REQ) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
                found = 1'b1;
            end
        end
    end

    assign grant        = lock ? lock_idx : rr_g;
    assign issue_ok     = inflight < 8'(MAX_INFLIGHT) && !flush_i;
    assign fpu_valid_o  = |req_valid_i && issue_ok;
    assign issue_hs     = fpu_valid_o && fpu_ready_i;
    assign fpu_data_o   = req_data_i[grant];
    assign fpu_tag_o    = grant;
    assign req_ready_o  = issue_hs ? NUM_REQ'(1) << grant : '0;
    assign fpu_flush_o  = flush_i;

    // Out-of-range tags are swallowed so a corrupt response can never wedge the FPU output.
    assign tag_ok       = {1'b0, fpu_rtag_i} < (ID_W+1)'(NUM_REQ);
    assign rdy_pad      = TAGS'(rsp_ready_i);
    assign fpu_rready_o = flush_i || !tag_ok || rdy_pad[fpu_rtag_i];
    assign rsp_valid_o  = (fpu_rvalid_i && tag_ok && !flush_i) ? NUM_REQ'(1) << fpu_rtag_i : '0;
    assign rsp_hs       = fpu_rvalid_i && fpu_rready_o;
    assign rsp_result_o = fpu_result_i;
    assign rsp_status_o = fpu_status_i;
    assign inflight_o   = inflight;
    assign busy_o       = inflight != '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
            inflight  <= '0;
            tag_err_o <= 1'b0;
        end else if (flush_i) begin
            inflight <= '0;
            lock     <= 1'b0;
        end else begin
            if (rsp_hs && (!tag_ok || inflight == '0))
                tag_err_o <= 1'b1;
            if (issue_hs && !(rsp_hs && inflight != '0))
                inflight <= inflight + 8'd1;
            else if (!issue_hs && rsp_hs && inflight != '0)
                inflight <= inflight - 8'd1;
            if (issue_hs) begin
                rr_ptr <= grant == ID_W'(NUM_REQ-1) ? '0 : grant + ID_W'(1);
                lock   <= 1'b0;
            end else if (fpu_valid_o) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
        end
    end
endmodule

// File: tb/tb_fpnew_issue_arbiter.sv
// tb_fpnew_issue_arbiter: randomized requesters and FPU model; expected outputs are queued
// by the driver and compared by an independent negedge monitor.
module tb_fpnew_issue_arbiter;
    localparam int N = 3, PW = 16, FL = 16, MAXI = 4, IW = 2;

    logic              clk_i = 1'b0, rst_ni = 1'b0;
    logic [N-1:0]      req_valid_i, req_ready_o;
    logic [N-1:0][PW-1:0] req_data_i;
    logic              fpu_valid_o, fpu_ready_i, fpu_flush_o, fpu_rvalid_i, fpu_rready_o;
    logic [PW-1:0]     fpu_data_o;
    logic [IW-1:0]     fpu_tag_o, fpu_rtag_i;
    logic [FL-1:0]     fpu_result_i, rsp_result_o;
    logic [4:0]        fpu_status_i, rsp_status_o;
    logic [N-1:0]      rsp_valid_o, rsp_ready_i;
    logic              flush_i, busy_o, tag_err_o;
    logic [7:0]        inflight_o;

    fpnew_issue_arbiter #(.NUM_REQ(N), .PAYLOAD_W(PW), .FLEN(FL), .MAX_INFLIGHT(MAXI)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_data_o(fpu_data_o),
        .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_rready_o(fpu_rready_o), .fpu_rtag_i(fpu_rtag_i),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_status_o(rsp_status_o),
        .flush_i(flush_i), .inflight_o(inflight_o), .busy_o(busy_o), .tag_err_o(tag_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          fv;
        logic [IW-1:0] tag;
        logic [PW-1:0] data;
        logic [N-1:0]  rdy;
        logic          rr;
        logic [N-1:0]  rv;
        logic [FL-1:0] res;
        logic [4:0]    st;
        logic          fl;
        logic [7:0]    cnt;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   vectors = 0, miscompares = 0;

    // Reference state: next search start, locked grant (-1 = none), outstanding count, sticky error
    int   ptr = 0, lock = -1, cnt = 0;
    bit   err = 1'b0;
    bit   pending [N];
    int   fpu_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            chk("fpu_valid", 32'(fpu_valid_o), 32'(m.fv));
            if (m.fv) begin
                chk("fpu_tag", 32'(fpu_tag_o), 32'(m.tag));
                chk("fpu_data", 32'(fpu_data_o), 32'(m.data));
            end
            chk("req_ready", 32'(req_ready_o), 32'(m.rdy));
            chk("fpu_rready", 32'(fpu_rready_o), 32'(m.rr));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(m.rv));
            if (m.rv != '0) begin
                chk("rsp_result", 32'(rsp_result_o), 32'(m.res));
                chk("rsp_status", 32'(rsp_status_o), 32'(m.st));
            end
            chk("fpu_flush", 32'(fpu_flush_o), 32'(m.fl));
            chk("inflight", 32'(inflight_o), 32'(m.cnt));
            chk("busy", 32'(busy_o), 32'(m.cnt != 0));
            chk("tag_err", 32'(tag_err_o), 32'(m.err));
        end
    end

    task automatic step(input bit allow_bad);
        exp_t e;
        int   g;
        bit   bad, any, fv, tok, rr, iss, rsp;
        @(posedge clk_i);
        #1;
        flush_i     = ($urandom_range(0, 24) == 0);
        fpu_ready_i = ($urandom_range(0, 3) != 0);
        rsp_ready_i = N'($urandom);
        for (int r = 0; r < N; r++) begin
            if (!pending[r] && $urandom_range(0, 1) == 1) begin
                pending[r]    = 1'b1;
                req_data_i[r] = PW'($urandom);
            end
            req_valid_i[r] = pending[r];
        end
        bad = allow_bad && $urandom_range(0, 9) == 0;
        if (bad) begin
            fpu_rvalid_i = 1'b1;
            fpu_rtag_i   = IW'(3);
        end else if (fpu_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            fpu_rvalid_i = 1'b1;
            fpu_rtag_i   = IW'(fpu_q[0]);
        end else begin
            fpu_rvalid_i = 1'b0;
            fpu_rtag_i   = IW'($urandom);
        end
        fpu_result_i = FL'($urandom);
        fpu_status_i = 5'($urandom);

        any = |req_valid_i;
        g   = lock;
        if (g < 0)
            for (int k = 0; k < N; k++)
                if (g < 0 && pending[(ptr + k) % N]) g = (ptr + k) % N;
        if (g < 0) g = 0;
        fv  = any && cnt < MAXI && !flush_i;
        tok = int'(fpu_rtag_i) < N;
        rr  = flush_i || !tok || rsp_ready_i[fpu_rtag_i];
        e.fv   = fv;
        e.tag  = IW'(g);
        e.data = req_data_i[IW'(g)];
        e.rdy  = (fv && fpu_ready_i) ? N'(1 << g) : '0;
        e.rr   = rr;
        e.rv   = (!flush_i && tok && fpu_rvalid_i) ? N'(1 << int'(fpu_rtag_i)) : '0;
        e.res  = fpu_result_i;
        e.st   = fpu_status_i;
        e.fl   = flush_i;
        e.cnt  = 8'(cnt);
        e.err  = err;
        exp_q.push_back(e);

        iss = fv && fpu_ready_i;
        rsp = fpu_rvalid_i && rr;
        if (flush_i) begin
            cnt  = 0;
            lock = -1;
            fpu_q.delete();
        end else begin
            if (rsp && (!tok || cnt == 0)) err = 1'b1;
            if (rsp && !bad) void'(fpu_q.pop_front());
            cnt = cnt + int'(iss) - int'(rsp && cnt > 0);
            if (iss) begin
                ptr        = (g + 1) % N;
                lock       = -1;
                pending[g] = 1'b0;
                fpu_q.push_back(g);
            end else if (fv) begin
                lock = g;
            end
        end
    endtask

    task automatic clear_stim();
        req_valid_i  = '0;
        req_data_i   = '0;
        fpu_ready_i  = 1'b0;
        fpu_rvalid_i = 1'b0;
        fpu_rtag_i   = '0;
        fpu_result_i = '0;
        fpu_status_i = '0;
        rsp_ready_i  = '0;
        flush_i      = 1'b0;
        for (int r = 0; r < N; r++) pending[r] = 1'b0;
        fpu_q.delete();
        ptr = 0; lock = -1; cnt = 0; err = 1'b0;
    endtask

    initial begin
        clear_stim();
        #12;
        chk("rst_fpu_valid", 32'(fpu_valid_o), 32'd0);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_inflight", 32'(inflight_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tag_err", 32'(tag_err_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 1500; c++) step(1'b0);
        for (int c = 0; c < 500; c++) step(1'b1);

        // Asynchronous reset between edges with traffic still applied
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_inflight", 32'(inflight_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_tag_err", 32'(tag_err_o), 32'd0);
        chk("arst_fpu_valid", 32'(fpu_valid_o), 32'(|req_valid_i && !flush_i));
        clear_stim();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 300; c++) step(1'b0);
        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
